// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the boot-time instruction-memory loader:
//   - loader state encoding
//   - header / trailer length in bytes
//   - I-BRAM byte-enable width and the all-lanes write mask
//   - word-index to byte-address helper
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_HEADER = 3'd0,
    ST_DATA   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  // Header, data words and checksum trailer all arrive as 4-byte groups.
  localparam int HDR_BYTES = 4;

  // I-BRAM byte-enable width and the full-word write mask.
  localparam int              BE_W       = 4;
  localparam logic [BE_W-1:0] BYTE_LANES = 4'b1111;

  // Byte address of word 'idx' relative to 'base' (32-bit unsigned wrap).
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// imem_loader_byte_packer
// Assembles a little-endian 32-bit word from a byte stream. The first byte
// of a group lands in bits [7:0]. word_vld pulses combinationally together
// with the handshake of the 4th byte, so the caller can register the word
// on that same edge. Reused for header, data words and checksum trailer.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   clr       synchronous clear of byte counter and partial word
//   byte_vld  a byte is transferred this cycle
//   byte_dat  the transferred byte
//   word_vld  4th byte of a group is being transferred
//   word_dat  assembled word (valid when word_vld)
// ---------------------------------------------------------------------------
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  logic [1:0]  cnt;
  logic [23:0] shreg;

  // New byte enters at the top; earlier bytes shift toward bit 0.
  assign word_dat = {byte_dat, shreg};
  assign word_vld = byte_vld && (cnt == 2'(HDR_BYTES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= 2'd0;
      shreg <= 24'd0;
    end else if (clr) begin
      cnt   <= 2'd0;
      shreg <= 24'd0;
    end else if (byte_vld) begin
      cnt   <= cnt + 2'd1;
      shreg <= word_dat[31:8];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot-time program loader driving the RV32I core's instruction BRAM write
// port and PC stall. Receives a byte stream: 4-byte little-endian word
// count N, then N little-endian instruction words written to consecutive
// word addresses from BASE_ADDR. The core stays held until the image is
// committed.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a 4-byte
// trailer equal to the mod-2^32 sum of the N data words.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   s_valid/s_data/s_ready   byte stream handshake
//   load_req      restart pulse, honoured in DONE or ERROR
//   mem_w_addr    I-BRAM byte address (word-aligned)
//   mem_w_dat     I-BRAM write data
//   mem_w_enb     one-cycle write strobe per word
//   mem_byte_enb  all lanes during a write, zero otherwise
//   cpu_hold      core PC stall
//   done          image loaded and valid
//   error         bad header or checksum mismatch
//   words_loaded  words written in the current load
// ---------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  input  logic [7:0]      s_data,
  output logic            s_ready,
  input  logic            load_req,
  output logic [31:0]     mem_w_addr,
  output logic [31:0]     mem_w_dat,
  output logic            mem_w_enb,
  output logic [BE_W-1:0] mem_byte_enb,
  output logic            cpu_hold,
  output logic            done,
  output logic            error,
  output logic [15:0]     words_loaded
);

  state_t      state;
  logic [15:0] last_idx;
  logic        fire;
  logic        restart;
  logic        word_vld;
  logic [31:0] word_dat;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum;
`endif

  assign fire    = s_valid && s_ready;
  // Restart also flushes the packer so a new load starts byte-aligned.
  assign restart = load_req && ((state == ST_DONE) || (state == ST_ERROR));

  imem_loader_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (restart),
    .byte_vld (fire),
    .byte_dat (s_data),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_HEADER;
      s_ready      <= 1'b1;
      mem_w_addr   <= BASE_ADDR;
      mem_w_dat    <= 32'd0;
      mem_w_enb    <= 1'b0;
      mem_byte_enb <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 16'd0;
      last_idx     <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= 32'd0;
`endif
    end else begin
      mem_w_enb    <= 1'b0;
      mem_byte_enb <= '0;
      case (state)
        ST_HEADER: begin
          if (word_vld) begin
            if ((word_dat == 32'd0) || (word_dat > 32'(MAX_WORDS))) begin
              state   <= ST_ERROR;
              s_ready <= 1'b0;
              error   <= 1'b1;
            end else begin
              state    <= ST_DATA;
              // N <= MAX_WORDS, so the low 16 bits carry the full count.
              last_idx <= word_dat[15:0] - 16'd1;
            end
          end
        end

        ST_DATA: begin
          if (word_vld) begin
            mem_w_addr   <= word_addr(BASE_ADDR, words_loaded);
            mem_w_dat    <= word_dat;
            mem_w_enb    <= 1'b1;
            mem_byte_enb <= BYTE_LANES;
            words_loaded <= words_loaded + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= csum + word_dat;
`endif
            if (words_loaded == last_idx) begin
              state   <= ST_COMMIT;
              s_ready <= 1'b0;
            end
          end
        end

        // Final write strobe is on the bus during this cycle.
        ST_COMMIT: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state   <= ST_CHECK;
          s_ready <= 1'b1;
`else
          state    <= ST_DONE;
          done     <= 1'b1;
          cpu_hold <= 1'b0;
`endif
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (word_vld) begin
            s_ready <= 1'b0;
            if (word_dat == csum) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
        end
`endif

        ST_DONE, ST_ERROR: begin
          if (load_req) begin
            state        <= ST_HEADER;
            s_ready      <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_hold     <= 1'b1;
            words_loaded <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= 32'd0;
`endif
          end
        end

        // Unreachable encodings park in ERROR with the core held.
        default: begin
          state    <= ST_ERROR;
          s_ready  <= 1'b0;
          error    <= 1'b1;
          cpu_hold <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Directed self-checking bench for imem_loader. Expected BRAM writes are
// queued when a data word's last byte is driven and compared when the
// strobe appears; a negedge monitor also checks strobe timing every cycle.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 1024;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        load_req;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_w_dat;
  logic        mem_w_enb;
  logic [3:0]  mem_byte_enb;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .load_req     (load_req),
    .mem_w_addr   (mem_w_addr),
    .mem_w_dat    (mem_w_dat),
    .mem_w_enb    (mem_w_enb),
    .mem_byte_enb (mem_byte_enb),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] dat;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         sb[$];
  logic        strobe_due = 1'b0;
  logic [31:0] exp_sum = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe must appear exactly in the cycle after a data word's 4th byte.
  always @(negedge clk) begin
    wr_t w;
    chk("strobe_timing", 32'(mem_w_enb), 32'(strobe_due));
    if (mem_w_enb) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(mem_w_enb), 32'd0);
      end else begin
        w = sb.pop_front();
        chk("wr_addr", mem_w_addr, w.addr);
        chk("wr_data", mem_w_dat, w.dat);
        chk("wr_byte_enb", 32'(mem_byte_enb), 32'hF);
      end
    end else begin
      chk("byte_enb_idle", 32'(mem_byte_enb), 32'd0);
    end
    strobe_due = 1'b0;
  end

  // All tasks start and end at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = b;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (!ok) chk("handshake_timeout", 32'(s_ready), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic send_data(input logic [31:0] w, input int idx, input int maxgap);
    wr_t e;
    for (int i = 0; i < 3; i++)
      send_byte(w[8*i +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    e.addr = BASE + 32'(idx) * 32'd4;
    e.dat  = w;
    sb.push_back(e);
    exp_sum = exp_sum + w;
    send_byte(w[31:24], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    strobe_due = 1'b1;
  endtask

  task automatic pulse_load_req(input logic with_byte);
    load_req = 1'b1;
    s_valid  = with_byte;
    s_data   = 8'hAA;
    @(posedge clk); #1;
    load_req = 1'b0;
    s_valid  = 1'b0;
    exp_sum  = 32'd0;
  endtask

  task automatic finish_image(input int n);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(exp_sum, 0);
    @(negedge clk);
    chk("words_loaded", 32'(words_loaded), 32'(n));
`else
    @(negedge clk);
    chk("done_in_commit", 32'(done), 32'd0);
    chk("hold_in_commit", 32'(cpu_hold), 32'd1);
    chk("words_loaded", 32'(words_loaded), 32'(n));
    @(negedge clk);
`endif
    chk("done_set", 32'(done), 32'd1);
    chk("hold_released", 32'(cpu_hold), 32'd0);
    chk("ready_in_done", 32'(s_ready), 32'd0);
    chk("no_error", 32'(error), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic expect_error(input string tag);
    @(negedge clk);
    chk({tag, "_error"}, 32'(error), 32'd1);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ready"}, 32'(s_ready), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    chk({tag, "_addr"}, mem_w_addr, BASE);
    chk({tag, "_dat"}, mem_w_dat, 32'd0);
    chk({tag, "_enb"}, 32'(mem_w_enb), 32'd0);
    chk({tag, "_byte_enb"}, 32'(mem_byte_enb), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    load_req = 1'b0;

    // Power-on reset values
    @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Two-word program, back-to-back bytes
    send_word(32'd2, 0);
    send_data(32'h0010_0513, 0, 0);
    send_data(32'h0020_0593, 1, 0);
    finish_image(2);

    // load_req wins over a simultaneous byte in DONE
    pulse_load_req(1'b1);
    @(negedge clk);
    chk("reload_ready", 32'(s_ready), 32'd1);
    chk("reload_words", 32'(words_loaded), 32'd0);
    chk("reload_hold", 32'(cpu_hold), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    @(posedge clk); #1;

    // One word with random gaps; a swallowed 0xAA would misalign the header
    send_word(32'd1, 0);
    send_data(32'hDEAD_BEEF, 0, 3);
    finish_image(1);

    // Zero-length header
    pulse_load_req(1'b0);
    send_word(32'd0, 0);
    expect_error("hdr_zero");

    // Oversized header (MAX_WORDS + 1)
    pulse_load_req(1'b0);
    send_word(32'd1025, 0);
    expect_error("hdr_big");

    // Reset after 6 data bytes of a 3-word image
    pulse_load_req(1'b0);
    send_word(32'd3, 0);
    send_data(32'hA1B2_C3D4, 0, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(posedge clk); #1;
    rst = 1'b1;
    exp_sum = 32'd0;
    @(posedge clk); #1;

    // Fresh image after abort restarts at BASE with a clean packer
    send_word(32'd2, 0);
    send_data(32'h1122_3344, 0, 1);
    send_data(32'h5566_7788, 1, 1);
    finish_image(2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum wraps mod 2^32: 1 + 0xFFFFFFFF = 0
    pulse_load_req(1'b0);
    send_word(32'd2, 0);
    send_data(32'h0000_0001, 0, 0);
    send_data(32'hFFFF_FFFF, 1, 0);
    finish_image(2);

    // Same image, wrong trailer
    pulse_load_req(1'b0);
    send_word(32'd2, 0);
    send_data(32'h0000_0001, 0, 0);
    send_data(32'hFFFF_FFFF, 1, 0);
    send_word(32'd1, 0);
    expect_error("csum_bad");
`endif

    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
